seq_shift_unit: RTL and testbench

- Multi-cycle shifter for the MIPS datapath. Executes SLL, SRL, SRA and ROTR one bit position per clock.
- Complements the fixed combinational left-by-2 address shifter. It adds the right-shift direction and variable amounts for R-type shift instructions.
- Sits beside the ALU and uses a start/done handshake so control can stall the PC while `busy` is high.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/shift_step.sv | 26 ++
 rtl/seq_shift_unit.sv | 106 ++++++++++
 tb/tb_seq_shift_unit.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath: shift op codes, shifter FSM
// state encoding and the default data path width.
package mips_pkg;

  localparam int WIDTH_DEFAULT = 32;

  // Shift operation codes as they appear on the shifter op port.
  typedef enum logic [1:0] {
    SH_SLL  = 2'b00,
    SH_SRL  = 2'b01,
    SH_SRA  = 2'b10,
    SH_ROTR = 2'b11
  } sh_op_e;

  // Sequential shifter control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } sh_state_e;

endpackage : mips_pkg

// File: rtl/shift_step.sv
// Single-position shifter: returns value moved by exactly one bit in the
// direction selected by op. Purely combinational.
module shift_step
  import mips_pkg::*;
#(
  parameter int width = WIDTH_DEFAULT
) (
  input  sh_op_e             op_i,
  input  logic [width-1:0]   value_i,
  output logic [width-1:0]   value_o
);

  // Select the one-bit move; the inserted bit depends on the operation.
  always_comb begin
    // NOTE: assign a default first so every path drives value_o and no latch is inferred.
    value_o = value_i;
    unique case (op_i)
      SH_SLL:  value_o = {value_i[width-2:0], 1'b0};
      SH_SRL:  value_o = {1'b0, value_i[width-1:1]};
      SH_SRA:  value_o = {value_i[width-1], value_i[width-1:1]};
      SH_ROTR: value_o = {value_i[0], value_i[width-1:1]};
      default: value_o = value_i;
    endcase
  end

endmodule : shift_step

// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter for R-type shift instructions. Moves the operand one
// bit per clock for shamt cycles, then pulses done with the result on out.
// busy is high while shifting so control can stall the PC.
module seq_shift_unit
  import mips_pkg::*;
#(
  parameter int width = WIDTH_DEFAULT,
  parameter int sh_w  = $clog2(width)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [width-1:0]  in,
  input  logic [sh_w-1:0]   shamt,
  output logic [width-1:0]  out,
  output logic              busy,
  output logic              done
);

  sh_state_e         state_q, state_d;
  logic [width-1:0]  work_q,  work_d;
  logic [sh_w-1:0]   count_q, count_d;
  sh_op_e            op_q,    op_d;

  logic              accept;
  logic [width-1:0]  stepped;

  // A new request can only be taken when no shift is in flight; a start
  // seen during SHIFT is dropped rather than queued.
  assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  shift_step #(
    .width (width)
  ) u_shift_step (
    .op_i    (op_q),
    .value_i (work_q),
    .value_o (stepped)
  );

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: non-blocking so all registers update from the same pre-edge values.
      state_q <= state_d;
    end
  end

  // Next-state logic: zero shift amount goes straight to DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = (shamt != '0) ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        if (count_q == sh_w'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (start) state_d = (shamt != '0) ? ST_SHIFT : ST_DONE;
        else       state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy = (state_q == ST_SHIFT);
    done = (state_q == ST_DONE);
  end

  // Datapath next values: load on accept, one-bit step while shifting,
  // otherwise hold so out stays stable in IDLE and DONE.
  always_comb begin
    work_d  = work_q;
    count_d = count_q;
    op_d    = op_q;
    if (accept) begin
      work_d  = in;
      count_d = shamt;
      op_d    = sh_op_e'(op);
    end else if (state_q == ST_SHIFT) begin
      work_d  = stepped;
      count_d = count_q - sh_w'(1);
    end
  end

  // Datapath registers; reset clears the result asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q  <= '0;
      count_q <= '0;
      op_q    <= SH_SLL;
    end else begin
      work_q  <= work_d;
      count_q <= count_d;
      op_q    <= op_d;
    end
  end

  assign out = work_q;

endmodule : seq_shift_unit

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_seq_shift_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  in_r;
  logic [4:0]    shamt;
  logic [W-1:0]  out;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fails  = 0;

  seq_shift_unit #(.width(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .in    (in_r),
    .shamt (shamt),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result computed from the instruction semantics directly.
  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x, input int s);
    logic [2*W-1:0] dbl;
    case (o)
      2'b00:   return x << s;
      2'b01:   return x >> s;
      2'b10:   return W'($signed(x) >>> s);
      default: begin
        dbl = {x, x} >> s;
        return dbl[W-1:0];
      end
    endcase
  endfunction

  // Called at a negedge: present a request that the next posedge accepts.
  task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input int s);
    start = 1'b1;
    op    = o;
    in_r  = x;
    shamt = 5'(s);
    @(posedge clk);
  endtask

  // Follows one operation to its done pulse; returns at the done negedge.
  task automatic wait_done(input string tag, input logic [W-1:0] exp, input int s,
                           input bit scramble);
    int k = 0;
    int busy_n = 0;
    for (int i = 1; i <= W + 4; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (done) begin
        k = i;
        break;
      end
      if (busy) busy_n++;
      if (scramble && i == 1) begin
        in_r = $urandom;
        op   = 2'($urandom);
      end
      if (scramble && s >= 3 && i == 2) start = 1'b1;
      if (scramble && s >= 3 && i == 3) start = 1'b0;
    end
    check({tag, " latency"}, W'(k), W'(s + 1));
    check({tag, " busy cycles"}, W'(busy_n), W'(s));
    check({tag, " out"}, out, exp);
    check({tag, " busy at done"}, W'(busy), W'(0));
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                     input int s, input logic [W-1:0] exp, input bit scramble);
    @(negedge clk);
    start_op(o, x, s);
    wait_done(tag, exp, s, scramble);
  endtask

  initial begin
    logic [1:0]   r_op;
    logic [W-1:0] r_in;
    int           r_s;
    int           done_n;

    rst = 1'b1; start = 1'b0; op = 2'b00; in_r = '0; shamt = '0;
    #12;
    check("reset out", out, '0);
    check("reset busy", W'(busy), W'(0));
    check("reset done", W'(done), W'(0));
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-operation: async clear, no done afterwards.
    @(negedge clk);
    start_op(2'b00, 32'h3, 8);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst out", out, '0);
    check("midrst busy", W'(busy), W'(0));
    @(negedge clk);
    rst = 1'b0;
    done_n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    check("midrst no done", W'(done_n), W'(0));

    run("sll3", 2'b00, 32'h3, 2, 32'h0000000C, 1'b0);
    run("sll1", 2'b00, 32'h1, 2, 32'h4, 1'b0);
    run("sll7", 2'b00, 32'h7, 2, 32'h1C, 1'b0);
    @(negedge clk);
    check("idle hold out", out, 32'h1C);
    check("idle done low", W'(done), W'(0));
    run("sra neg", 2'b10, 32'h80000010, 4, 32'hF8000001, 1'b0);
    run("srl neg", 2'b01, 32'h80000010, 4, 32'h08000001, 1'b0);
    run("rotr31", 2'b11, 32'h1, 31, 32'h2, 1'b0);
    run("shamt0", 2'b10, 32'hDEADBEEF, 0, 32'hDEADBEEF, 1'b0);
    run("ignore start", 2'b00, 32'h00F0000F, 6, 32'h3C0003C0, 1'b1);

    // Back-to-back: new request presented in the DONE cycle.
    @(negedge clk);
    start_op(2'b00, 32'h5, 3);
    wait_done("b2b first", 32'h28, 3, 1'b0);
    start_op(2'b01, 32'h10, 4);
    wait_done("b2b second", 32'h1, 4, 1'b0);

    // Randomized operations, some back-to-back, with input scrambling.
    for (int t = 0; t < 30; t++) begin
      r_op = 2'($urandom);
      r_in = $urandom;
      r_s  = $urandom_range(0, W - 1);
      if (t % 3 != 0) @(negedge clk);
      start_op(r_op, r_in, r_s);
      wait_done($sformatf("rand%0d op%0d s%0d", t, r_op, r_s), model(r_op, r_in, r_s), r_s, 1'b1);
    end
    @(negedge clk);
    check("final done low", W'(done), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_seq_shift_unit
